// File: rtl/axis_seq_divider_if.sv
// axis_seq_divider_if: operand and result channels of the sequential divider.
// The divider uses the slave modport; the divide unit driving it uses master.
interface axis_seq_divider_if #(
   parameter int DATA_W = 32
);
   logic                s_axis_dividend_tvalid;
   logic [DATA_W-1:0]   s_axis_dividend_tdata;
   logic                s_axis_dividend_tready;
   logic                s_axis_divisor_tvalid;
   logic [DATA_W-1:0]   s_axis_divisor_tdata;
   logic                s_axis_divisor_tready;
   logic                m_axis_dout_tvalid;
   logic [2*DATA_W-1:0] m_axis_dout_tdata;

   modport master (
      output s_axis_dividend_tvalid,
      output s_axis_dividend_tdata,
      input  s_axis_dividend_tready,
      output s_axis_divisor_tvalid,
      output s_axis_divisor_tdata,
      input  s_axis_divisor_tready,
      input  m_axis_dout_tvalid,
      input  m_axis_dout_tdata
   );

   modport slave (
      input  s_axis_dividend_tvalid,
      input  s_axis_dividend_tdata,
      output s_axis_dividend_tready,
      input  s_axis_divisor_tvalid,
      input  s_axis_divisor_tdata,
      output s_axis_divisor_tready,
      output m_axis_dout_tvalid,
      output m_axis_dout_tdata
   );
endinterface

// File: rtl/axis_seq_divider.sv
// axis_seq_divider: radix-2 restoring divider, one quotient bit per cycle.
// Define DIV_SIGNED_EN for two's-complement signed division (default unsigned).
module axis_seq_divider #(
   parameter int DATA_W = 32
) (
   input logic               aclk,
   input logic               aresetn,
   axis_seq_divider_if.slave bus
);
   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } state_t;

   state_t              state;
   logic                got_dd;
   logic                got_dv;
   logic [DATA_W-1:0]   dd_q;
   logic [DATA_W-1:0]   dv_q;
   logic [DATA_W-1:0]   quo;
   logic [DATA_W-1:0]   rem;
   logic [DATA_W-1:0]   dvs;
   logic [CNT_W-1:0]    cnt;
   logic                dout_valid;
   logic [2*DATA_W-1:0] dout_data;

   logic                rdy_dd;
   logic                rdy_dv;
   logic                acc_dd;
   logic                acc_dv;
   logic                start;
   logic                dz;
   logic [DATA_W-1:0]   dd_in;
   logic [DATA_W-1:0]   dv_in;
   logic [DATA_W-1:0]   dd_mag;
   logic [DATA_W-1:0]   dv_mag;
   logic [DATA_W:0]     shl;
   logic [DATA_W:0]     diff;
   logic [DATA_W-1:0]   rem_nxt;
   logic [DATA_W-1:0]   quo_nxt;
   logic [DATA_W-1:0]   q_fix;
   logic [DATA_W-1:0]   r_fix;

   always_comb begin
      rdy_dd = (state == IDLE) & ~got_dd;
      rdy_dv = (state == IDLE) & ~got_dv;
      acc_dd = bus.s_axis_dividend_tvalid & rdy_dd;
      acc_dv = bus.s_axis_divisor_tvalid & rdy_dv;
      start  = (state == IDLE)
             & (got_dd | acc_dd)
             & (got_dv | acc_dv);
      dd_in  = acc_dd ? bus.s_axis_dividend_tdata : dd_q;
      dv_in  = acc_dv ? bus.s_axis_divisor_tdata : dv_q;
`ifdef DIV_SIGNED_EN
      dd_mag = dd_in[DATA_W-1] ? -dd_in : dd_in;
      dv_mag = dv_in[DATA_W-1] ? -dv_in : dv_in;
`else
      dd_mag = dd_in;
      dv_mag = dv_in;
`endif
   end

   // diff MSB set means the trial subtraction went negative: restore.
   always_comb begin
      shl  = {rem, quo[DATA_W-1]};
      diff = shl - {1'b0, dvs};
      if (!diff[DATA_W]) begin
         rem_nxt = diff[DATA_W-1:0];
         quo_nxt = {quo[DATA_W-2:0], 1'b1};
      end else begin
         rem_nxt = shl[DATA_W-1:0];
         quo_nxt = {quo[DATA_W-2:0], 1'b0};
      end
   end

   always_comb begin
      dz = (dv_q == '0);
`ifdef DIV_SIGNED_EN
      q_fix = (dd_q[DATA_W-1] ^ dv_q[DATA_W-1]) ? -quo : quo;
      r_fix = dd_q[DATA_W-1] ? -rem : rem;
`else
      q_fix = quo;
      r_fix = rem;
`endif
      if (dz) begin
         q_fix = '1;
         r_fix = dd_q;
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state      <= IDLE;
         got_dd     <= 1'b0;
         got_dv     <= 1'b0;
         cnt        <= '0;
         dd_q       <= '0;
         dv_q       <= '0;
         quo        <= '0;
         rem        <= '0;
         dvs        <= '0;
         dout_valid <= 1'b0;
         dout_data  <= '0;
      end else begin
         dout_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (acc_dd) begin
                  dd_q   <= bus.s_axis_dividend_tdata;
                  got_dd <= 1'b1;
               end
               if (acc_dv) begin
                  dv_q   <= bus.s_axis_divisor_tdata;
                  got_dv <= 1'b1;
               end
               if (start) begin
                  quo   <= dd_mag;
                  dvs   <= dv_mag;
                  rem   <= '0;
                  cnt   <= '0;
                  state <= CALC;
               end
            end
            CALC: begin
               quo <= quo_nxt;
               rem <= rem_nxt;
               if (cnt == LAST) begin
                  state <= FIX;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            FIX: begin
               dout_valid <= 1'b1;
               dout_data  <= {q_fix, r_fix};
               state      <= DONE;
            end
            DONE: begin
               got_dd <= 1'b0;
               got_dv <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.s_axis_dividend_tready = rdy_dd;
   assign bus.s_axis_divisor_tready  = rdy_dv;
   assign bus.m_axis_dout_tvalid     = dout_valid;
   assign bus.m_axis_dout_tdata      = dout_data;
endmodule

// File: tb/tb_axis_seq_divider.sv
// tb_axis_seq_divider: scoreboard bench for axis_seq_divider (DATA_W = 32).
// Expected beats and their arrival cycle are queued when operands are accepted.
module tb_axis_seq_divider;
   localparam int W = 32;

   typedef struct {
      logic [2*W-1:0] data;
      int             t;
   } exp_t;

   logic   clk = 1'b0;
   logic   rstn = 1'b0;
   int     cyc = 0;
   int     n_chk = 0;
   int     n_fail = 0;
   int     pulse_cnt = 0;
   logic   prev_v = 1'b0;
   exp_t   sb[$];

   axis_seq_divider_if #(.DATA_W(W)) bus ();

   axis_seq_divider #(.DATA_W(W)) dut (
      .aclk    (clk),
      .aresetn (rstn),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin : mon
      exp_t e;
      if (bus.m_axis_dout_tvalid === 1'b1) begin
         pulse_cnt++;
         n_chk++;
         if (prev_v === 1'b1) begin
            n_fail++;
            $display("FAIL pulse_width: tvalid high two cycles at cyc %0d", cyc);
         end
         n_chk++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_beat: got %h at cyc %0d, none expected",
                     bus.m_axis_dout_tdata, cyc);
         end else begin
            e = sb.pop_front();
            if (bus.m_axis_dout_tdata !== e.data) begin
               n_fail++;
               $display("FAIL result_data: got %h, expected %h",
                        bus.m_axis_dout_tdata, e.data);
            end
            n_chk++;
            if (cyc !== e.t) begin
               n_fail++;
               $display("FAIL result_time: got cyc %0d, expected cyc %0d", cyc, e.t);
            end
         end
      end
      prev_v = bus.m_axis_dout_tvalid;
   end

   function automatic logic [2*W-1:0] model(input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      logic [W-1:0] q;
      logic [W-1:0] r;
      if (b == '0) return {{W{1'b1}}, a};
`ifdef DIV_SIGNED_EN
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
`else
      q = a / b;
      r = a % b;
`endif
      return {q, r};
   endfunction

   task automatic put_both(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2*W-1:0] exp_d, output int k);
      int g = 0;
      @(negedge clk);
      bus.s_axis_dividend_tdata  = a;
      bus.s_axis_divisor_tdata   = b;
      bus.s_axis_dividend_tvalid = 1'b1;
      bus.s_axis_divisor_tvalid  = 1'b1;
      while (!(bus.s_axis_dividend_tready && bus.s_axis_divisor_tready) && g < 200) begin
         @(negedge clk);
         g++;
      end
      if (g >= 200) begin
         n_chk++;
         n_fail++;
         $display("FAIL accept_timeout: tready low for %0d cycles", g);
      end
      @(posedge clk);
      #1;
      k = cyc;
      sb.push_back('{exp_d, k + W + 1});
      bus.s_axis_dividend_tvalid = 1'b0;
      bus.s_axis_divisor_tvalid  = 1'b0;
   endtask

   task automatic drain();
      int g = 0;
      while (sb.size() != 0 && g < 200) begin
         @(posedge clk);
         g++;
      end
      n_chk++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
         sb.delete();
      end
      repeat (2) @(posedge clk);
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      n_chk++;
      if (bus.m_axis_dout_tvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_tvalid: got %b, expected 0", bus.m_axis_dout_tvalid);
      end
      n_chk++;
      if (bus.m_axis_dout_tdata !== '0) begin
         n_fail++;
         $display("FAIL reset_tdata: got %h, expected 0", bus.m_axis_dout_tdata);
      end
      n_chk++;
      if (bus.s_axis_dividend_tready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_dd_ready: got %b, expected 1", bus.s_axis_dividend_tready);
      end
      n_chk++;
      if (bus.s_axis_divisor_tready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_dv_ready: got %b, expected 1", bus.s_axis_divisor_tready);
      end
   endtask

   task automatic test_basic();
      int k;
      put_both(32'd100, 32'd7, 64'h0000000E_00000002, k);
      @(negedge clk);
      n_chk++;
      if (bus.s_axis_dividend_tready !== 1'b0 || bus.s_axis_divisor_tready !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_ready: got %b/%b, expected 0/0",
                  bus.s_axis_dividend_tready, bus.s_axis_divisor_tready);
      end
      drain();
   endtask

   task automatic test_signed();
      int k;
`ifdef DIV_SIGNED_EN
      put_both(32'hFFFFFFF9, 32'd2, 64'hFFFFFFFD_FFFFFFFF, k);
      drain();
      put_both(32'd7, 32'hFFFFFFFE, 64'hFFFFFFFD_00000001, k);
`else
      put_both(32'hFFFFFFF9, 32'd2, 64'h7FFFFFFC_00000001, k);
      drain();
      put_both(32'd7, 32'hFFFFFFFE, 64'h00000000_00000007, k);
`endif
      drain();
   endtask

   task automatic test_special();
      int k;
      put_both(32'd5, 32'd0, 64'hFFFFFFFF_00000005, k);
      drain();
      put_both(32'hFFFFFFFB, 32'd0, 64'hFFFFFFFF_FFFFFFFB, k);
      drain();
`ifdef DIV_SIGNED_EN
      put_both(32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, k);
`else
      put_both(32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, k);
`endif
      drain();
   endtask

   task automatic test_staggered();
      int e0;
      int k;
      @(negedge clk);
      bus.s_axis_dividend_tdata  = 32'd50;
      bus.s_axis_dividend_tvalid = 1'b1;
      @(posedge clk);
      #1;
      e0 = cyc;
      bus.s_axis_dividend_tvalid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_chk++;
         if (bus.s_axis_dividend_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL stagger_dd_ready: cycle %0d got %b, expected 0",
                     i + 1, bus.s_axis_dividend_tready);
         end
      end
      n_chk++;
      if (bus.s_axis_divisor_tready !== 1'b1) begin
         n_fail++;
         $display("FAIL stagger_dv_ready: got %b, expected 1", bus.s_axis_divisor_tready);
      end
      bus.s_axis_divisor_tdata  = 32'd3;
      bus.s_axis_divisor_tvalid = 1'b1;
      @(posedge clk);
      #1;
      k = cyc;
      sb.push_back('{64'h00000010_00000002, e0 + 5 + W + 1});
      bus.s_axis_divisor_tvalid = 1'b0;
      n_chk++;
      if (k !== e0 + 5) begin
         n_fail++;
         $display("FAIL stagger_accept: got cyc %0d, expected cyc %0d", k, e0 + 5);
      end
      drain();
   endtask

   task automatic test_reset_mid();
      int k;
      int p0;
      put_both(32'd1000, 32'd3, model(32'd1000, 32'd3), k);
      repeat (10) @(posedge clk);
      @(negedge clk);
      rstn = 1'b0;
      sb.delete();
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      p0 = pulse_cnt;
      @(negedge clk);
      n_chk++;
      if (bus.s_axis_dividend_tready !== 1'b1 || bus.s_axis_divisor_tready !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_ready: got %b/%b, expected 1/1",
                  bus.s_axis_dividend_tready, bus.s_axis_divisor_tready);
      end
      n_chk++;
      if (bus.m_axis_dout_tdata !== '0) begin
         n_fail++;
         $display("FAIL midrst_tdata: got %h, expected 0", bus.m_axis_dout_tdata);
      end
      repeat (W + 10) @(negedge clk);
      n_chk++;
      if (pulse_cnt - p0 !== 0) begin
         n_fail++;
         $display("FAIL midrst_pulse: got %0d pulses, expected 0", pulse_cnt - p0);
      end
      put_both(32'd9, 32'd3, 64'h00000003_00000000, k);
      drain();
   endtask

   task automatic test_held_valid();
      int k;
      int k2;
      int p0;
      int g;
      for (int extra = 0; extra < 2; extra++) begin
         p0 = pulse_cnt;
         g  = 0;
         @(negedge clk);
         bus.s_axis_dividend_tdata  = 32'd20;
         bus.s_axis_divisor_tdata   = 32'd6;
         bus.s_axis_dividend_tvalid = 1'b1;
         bus.s_axis_divisor_tvalid  = 1'b1;
         @(posedge clk);
         #1;
         k = cyc;
         sb.push_back('{64'h00000003_00000002, k + W + 1});
         while (bus.m_axis_dout_tvalid !== 1'b1 && g < 100) begin
            @(negedge clk);
            g++;
         end
         @(posedge clk);
         #1;
         if (extra == 1) begin
            @(negedge clk);
            n_chk++;
            if (bus.s_axis_dividend_tready !== 1'b1 || bus.s_axis_divisor_tready !== 1'b1) begin
               n_fail++;
               $display("FAIL held_ready: got %b/%b, expected 1/1",
                        bus.s_axis_dividend_tready, bus.s_axis_divisor_tready);
            end
            @(posedge clk);
            #1;
            k2 = cyc;
            sb.push_back('{64'h00000003_00000002, k2 + W + 1});
            n_chk++;
            if (k2 !== k + W + 3) begin
               n_fail++;
               $display("FAIL held_restart: got cyc %0d, expected cyc %0d", k2, k + W + 3);
            end
         end
         bus.s_axis_dividend_tvalid = 1'b0;
         bus.s_axis_divisor_tvalid  = 1'b0;
         repeat (W + 10) @(negedge clk);
         n_chk++;
         if (pulse_cnt - p0 !== extra + 1) begin
            n_fail++;
            $display("FAIL held_pulses: got %0d, expected %0d", pulse_cnt - p0, extra + 1);
         end
         drain();
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] a;
      logic [W-1:0] b;
      int k;
      int kp = 0;
      for (int i = 0; i < 8; i++) begin
         a = $urandom;
         b = (i % 3 == 0) ? W'($urandom_range(1, 15)) : W'($urandom);
         if (i == 5) b = '0;
         if (a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd3;
         put_both(a, b, model(a, b), k);
         if (i > 0) begin
            n_chk++;
            if (k - kp !== W + 3) begin
               n_fail++;
               $display("FAIL b2b_spacing: got %0d cycles, expected %0d", k - kp, W + 3);
            end
         end
         kp = k;
      end
      drain();
   endtask

   initial begin
      bus.s_axis_dividend_tvalid = 1'b0;
      bus.s_axis_divisor_tvalid  = 1'b0;
      bus.s_axis_dividend_tdata  = '0;
      bus.s_axis_divisor_tdata   = '0;
      test_reset();
      test_basic();
      test_signed();
      test_special();
      test_staggered();
      test_reset_mid();
      test_held_valid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/axis_seq_divider.md
# axis_seq_divider

Iterative radix-2 divider with AXI-Stream style operand and result channels. It is the responder end of the dividend/divisor/dout handshake driven by the core's divide functional unit, and is a drop-in RTL replacement for the vendor divider IP. It accepts one dividend and one divisor, and produces quotient and remainder on a single result beat. It holds one operation at a time.

## Interface
- `DATA_W`, default 32: operand width. Iteration count equals `DATA_W`.
- `aclk` in 1: clock; all logic updates on the rising edge.
- `aresetn` in 1: reset, synchronous, active-low.
- `s_axis_dividend_tvalid` in 1: dividend valid.
- `s_axis_dividend_tdata` in DATA_W: dividend.
- `s_axis_dividend_tready` out 1: dividend channel can accept.
- `s_axis_divisor_tvalid` in 1: divisor valid.
- `s_axis_divisor_tdata` in DATA_W: divisor.
- `s_axis_divisor_tready` out 1: divisor channel can accept.
- `m_axis_dout_tvalid` out 1: one-cycle result pulse. There is no tready; the consumer must sample it.
- `m_axis_dout_tdata` out 2*DATA_W: `[2W-1:W]` is the quotient, `[W-1:0]` is the remainder.

## Operation
- **States:**
  - IDLE: operand capture.
  - CALC: `DATA_W` iterations.
  - FIX: sign correction and special cases.
  - DONE: result beat.
- **Capture (per channel):**
  - Each channel has a holding register and a `got` flag.
  - `tready = (state==IDLE) & ~got`.
  - A beat is accepted on an edge where `tvalid & tready`.
  - The channels are independent: either may arrive first, or both may arrive on the same edge.
- **IDLE→CALC:** occurs on the edge where the second operand is accepted, or both are accepted together. At that edge:
  - magnitudes are loaded;
  - the partial remainder is cleared;
  - the counter is cleared.
- **CALC:** performs a restoring shift-subtract, one quotient bit per cycle, MSB first. After `DATA_W` iterations the block moves to FIX.
- **FIX:** sets the final quotient and remainder, then moves to DONE.
  - Divisor == 0: quotient = all ones; remainder = original dividend.
  - Otherwise (signed build): quotient is negated when the operand signs differ; remainder takes the sign of the dividend.
  - `-2^(W-1) / -1` yields quotient `-2^(W-1)` and remainder 0. This falls out of the magnitude path and needs no special case.
- **DONE:**
  - `m_axis_dout_tvalid=1` and `tdata` is updated.
  - Both `got` flags clear.
  - Next state is IDLE.
- **Result data:** `m_axis_dout_tdata` holds the last result until the next DONE overwrites it.
- **Streaming:** if the initiator still holds `tvalid` high in the IDLE cycle after DONE, a new operation is accepted. Initiators that want one result must drop valid on the result edge.
- **Busy period:** during CALC, FIX and DONE both treadys are 0. Input valids are ignored and never lost silently, because the initiator sees tready low.

## Timing
- **Reset values:** `aresetn` low at any edge forces:
  - state = IDLE;
  - `got` flags = 0;
  - counter = 0;
  - `m_axis_dout_tvalid` = 0;
  - `m_axis_dout_tdata` = 0;
  - both treadys = 1 in the cycle after reset deasserts.
- **Reset mid-operation:** an operation in flight is discarded and no result pulse is produced.
- **Latency:** second operand accepted at edge k, then:
  - CALC occupies edges k+1 to k+DATA_W;
  - FIX occurs at edge k+DATA_W+1;
  - `m_axis_dout_tvalid` is high during the cycle after edge k+DATA_W+1 (k+33 for W=32), for exactly one cycle.
- **Earliest next acceptance:** edge k+DATA_W+3.
- **Throughput:** one result per DATA_W+3 cycles at most.
- **Outputs:** `tready`, `tvalid` and `tdata` are registered, or decoded from registered state only. There is no combinational path from inputs to outputs.

## Configuration
- **`DIV_SIGNED_EN` defined:**
  - two's-complement signed division;
  - magnitude conversion on entry, sign fix in FIX;
  - quotient truncates toward zero.
- **`DIV_SIGNED_EN` undefined:**
  - unsigned division;
  - no sign logic; FIX applies only the divide-by-zero rule;
  - latency is unchanged.

## Test plan
- **Basic, both operands same cycle:** 100 / 7 → `tdata = 0x0000000E_00000002`, tvalid exactly 33 cycles after the accept edge, high for 1 cycle.
- **Signed (`DIV_SIGNED_EN`):** -7 / 2 → `0xFFFFFFFD_FFFFFFFF`. Unsigned build: 0xFFFFFFF9 / 2 → `0x7FFFFFFC_00000001`.
- **Special cases:**
  - 5 / 0 → `0xFFFFFFFF_00000005`;
  - -5 / 0 → `0xFFFFFFFF_FFFFFFFB`;
  - 0x80000000 / 0xFFFFFFFF (signed) → `0x80000000_00000000`.
- **Staggered operands:**
  - dividend 50 at cycle 0, divisor 3 at cycle 5;
  - dividend tready is low in cycles 1–5;
  - result `0x00000010_00000002` appears 33 cycles after cycle 5.
- **Reset mid-CALC:**
  - `aresetn` low at CALC iteration 10 → no tvalid pulse;
  - both treadys high after release;
  - a following 9 / 3 → `0x00000003_00000000`.
- **FU-style held valid:**
  - both valids held high until the edge sampling tvalid, then dropped;
  - exactly one result is produced and no second operation starts;
  - with valids held one extra cycle, a second operation starts in IDLE.
